// File: rtl/reg_window_write_decoder_pkg.sv
// Shared definitions for the SPARC register-window write decoder.
// Contents: default sizing constants, index widths, window-operation enum,
// and modular CWP increment/decrement helpers used by the top level.
package reg_window_pkg;

  localparam int NWINDOWS_DEFAULT  = 3;
  localparam int PHYS_REGS_DEFAULT = 64;
  localparam int NUM_GLOBALS       = 8;
  localparam int WINDOW_STRIDE     = 16;
  localparam int ARCH_W            = 5;
  localparam int PHYS_W            = 6;
  localparam int CWP_W             = 5;

  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [CWP_W-1:0]  cwp_t;

  // Requested window rotation after save/restore arbitration.
  typedef enum logic [1:0] {
    WOP_NONE    = 2'd0,
    WOP_SAVE    = 2'd1,
    WOP_RESTORE = 2'd2
  } win_op_t;

  // RESTORE direction: (c + 1) mod nwin, with nwin the window count.
  function automatic cwp_t cwp_inc(input cwp_t c, input cwp_t nwin);
    cwp_t r;
    if (c == nwin - cwp_t'(1)) r = '0;
    else                       r = c + cwp_t'(1);
    return r;
  endfunction

  // SAVE direction: (c + nwin - 1) mod nwin.
  function automatic cwp_t cwp_dec(input cwp_t c, input cwp_t nwin);
    cwp_t r;
    if (c == '0) r = nwin - cwp_t'(1);
    else         r = c - cwp_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/reg_window_write_decoder_if.sv
// Bus bundle between a register-write requester and the window decoder.
// master: drives write requests, window ops and CWP/WIM loads; observes
//         the one-hot enable, aligned data, CWP/WIM state and trap pulses.
// slave : the decoder side of the same signals.
interface reg_window_write_decoder_if #(
  parameter int NWINDOWS  = 3,
  parameter int PHYS_REGS = 64,
  parameter int DATA_W    = 32
);
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 save;
  logic                 restore;
  logic                 wr_cwp;
  logic [4:0]           cwp_in;
  logic                 wr_wim;
  logic [NWINDOWS-1:0]  wim_in;
  logic [PHYS_REGS-1:0] we;
  logic [DATA_W-1:0]    wdata;
  logic [4:0]           cwp;
  logic [NWINDOWS-1:0]  wim;
  logic                 trap_overflow;
  logic                 trap_underflow;

  modport master (
    output wr_en, wr_addr, wr_data, save, restore, wr_cwp, cwp_in, wr_wim, wim_in,
    input  we, wdata, cwp, wim, trap_overflow, trap_underflow
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, save, restore, wr_cwp, cwp_in, wr_wim, wim_in,
    output we, wdata, cwp, wim, trap_overflow, trap_underflow
  );
endinterface

// File: rtl/reg_window_write_decoder_window_addr_map.sv
// Combinational architectural-to-physical register index map.
// Inputs : cwp (current window pointer), arch_addr (r0..r31).
// Outputs: phys_idx (physical register index), valid (low for r0 and for
//          any index outside the populated physical range).
// Globals r0..r7 map straight through; r8..r31 map into a circular span of
// WINDOW_STRIDE*NWINDOWS registers so the ins of window w alias the outs of
// window w+1.
module window_addr_map
  import reg_window_pkg::*;
#(
  parameter int NWINDOWS = NWINDOWS_DEFAULT
) (
  input  cwp_t      cwp,
  input  arch_idx_t arch_addr,
  output phys_idx_t phys_idx,
  output logic      valid
);

  localparam int SPAN = WINDOW_STRIDE * NWINDOWS;
  localparam int USED = NUM_GLOBALS + SPAN;

  logic [10:0] win_off;
  logic [10:0] phys_full;

  always_comb begin
    win_off   = '0;
    phys_full = '0;
    if (arch_addr < arch_idx_t'(NUM_GLOBALS)) begin
      phys_full = {6'd0, arch_addr};
    end else begin
      // cwp < NWINDOWS and (r-8) < 24 keep the sum below 2*SPAN, so a single
      // conditional subtract replaces a general modulo.
      win_off = {2'd0, cwp, 4'd0} + {6'd0, arch_addr - arch_idx_t'(NUM_GLOBALS)};
      if (win_off >= 11'(SPAN)) win_off = win_off - 11'(SPAN);
      phys_full = win_off + 11'(NUM_GLOBALS);
    end
    phys_idx = phys_full[PHYS_W-1:0];
    valid    = (arch_addr != '0) && (phys_full < 11'(USED));
  end

endmodule

// File: rtl/reg_window_write_decoder.sv
// Register-window write decoder.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
//        reg_window_write_decoder_if) carrying the write request, SAVE/RESTORE,
//        CWP/WIM loads, the registered one-hot write enable with aligned data,
//        current CWP/WIM, and single-cycle overflow/underflow trap pulses.
// A write request is decoded against the CWP held before the edge and appears
// as a one-hot enable one cycle later.
module reg_window_write_decoder
  import reg_window_pkg::*;
#(
  parameter int NWINDOWS  = NWINDOWS_DEFAULT,
  parameter int PHYS_REGS = PHYS_REGS_DEFAULT,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  reg_window_write_decoder_if.slave bus
);

  localparam cwp_t NW5 = cwp_t'(NWINDOWS);

  logic [PHYS_REGS-1:0] we_p1;
  logic [DATA_W-1:0]    wdata_p1;
  cwp_t                 cwp_q;
  logic [NWINDOWS-1:0]  wim_q;
  logic                 trap_ovf_q;
  logic                 trap_unf_q;

  phys_idx_t            phys_idx;
  logic                 map_valid;
  logic [PHYS_REGS-1:0] we_next;
  win_op_t              win_op;
  cwp_t                 cwp_target;
  logic [NWINDOWS-1:0]  wim_shifted;
  logic                 target_invalid;

  window_addr_map #(.NWINDOWS(NWINDOWS)) u_map (
    .cwp       (cwp_q),
    .arch_addr (bus.wr_addr),
    .phys_idx  (phys_idx),
    .valid     (map_valid)
  );

  always_comb begin
    we_next = '0;
    if (bus.wr_en && map_valid) we_next = PHYS_REGS'(1) << phys_idx;
  end

  // save and restore together cancel out.
  always_comb begin
    win_op = WOP_NONE;
    if (bus.save && !bus.restore)      win_op = WOP_SAVE;
    else if (bus.restore && !bus.save) win_op = WOP_RESTORE;
  end

  // Validity is judged against the WIM held before the edge, so a same-cycle
  // wr_wim never affects the rotation check.
  always_comb begin
    cwp_target     = (win_op == WOP_SAVE) ? cwp_dec(cwp_q, NW5) : cwp_inc(cwp_q, NW5);
    wim_shifted    = wim_q >> cwp_target;
    target_invalid = wim_shifted[0];
  end

  // Stage p0 -> p1: registered enable/data, CWP/WIM state, trap pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_p1      <= '0;
      wdata_p1   <= '0;
      cwp_q      <= '0;
      wim_q      <= '0;
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
    end else begin
      trap_ovf_q <= 1'b0;
      trap_unf_q <= 1'b0;
      we_p1      <= we_next;
      if (bus.wr_en) wdata_p1 <= bus.wr_data;
      if (bus.wr_wim) wim_q <= bus.wim_in;

      // An out-of-range wr_cwp is dropped but still blocks save/restore.
      if (bus.wr_cwp) begin
        if (bus.cwp_in < NW5) cwp_q <= bus.cwp_in;
      end else begin
        case (win_op)
          WOP_SAVE: begin
            if (target_invalid) trap_ovf_q <= 1'b1;
            else                cwp_q      <= cwp_target;
          end
          WOP_RESTORE: begin
            if (target_invalid) trap_unf_q <= 1'b1;
            else                cwp_q      <= cwp_target;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.we             = we_p1;
  assign bus.wdata          = wdata_p1;
  assign bus.cwp            = cwp_q;
  assign bus.wim            = wim_q;
  assign bus.trap_overflow  = trap_ovf_q;
  assign bus.trap_underflow = trap_unf_q;

endmodule

// File: tb/tb_reg_window_write_decoder.sv
// Self-checking bench for reg_window_write_decoder: directed steps followed
// by random traffic, all compared against a behavioural model of the
// window/address rules.
module tb_reg_window_write_decoder;

  localparam int NW   = 3;
  localparam int PR   = 64;
  localparam int DW   = 32;
  localparam int SPAN = 16 * NW;

  logic clk = 1'b0;
  logic reset;

  reg_window_write_decoder_if #(.NWINDOWS(NW), .PHYS_REGS(PR), .DATA_W(DW)) bus ();

  reg_window_write_decoder #(.NWINDOWS(NW), .PHYS_REGS(PR), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [PR-1:0] e_we;
  logic [DW-1:0] e_wdata;
  int            m_cwp;
  logic [NW-1:0] m_wim;
  logic          e_tov;
  logic          e_tun;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.save    = 1'b0;
    bus.restore = 1'b0;
    bus.wr_cwp  = 1'b0;
    bus.cwp_in  = '0;
    bus.wr_wim  = 1'b0;
    bus.wim_in  = '0;
    reset       = 1'b0;
  endtask

  // Apply the architectural rules to the inputs present at the coming edge.
  task automatic model_edge();
    int r, p, n;
    logic [NW-1:0] old_wim;
    if (reset) begin
      e_we = '0; e_wdata = '0; m_cwp = 0; m_wim = '0; e_tov = 0; e_tun = 0;
      return;
    end
    e_tov = 0;
    e_tun = 0;
    e_we  = '0;
    if (bus.wr_en) begin
      r = int'(bus.wr_addr);
      if (r != 0) begin
        if (r < 8) p = r;
        else       p = 8 + ((m_cwp * 16 + (r - 8)) % SPAN);
        e_we[p] = 1'b1;
      end
      e_wdata = bus.wr_data;
    end
    old_wim = m_wim;
    if (bus.wr_wim) m_wim = bus.wim_in;
    if (bus.wr_cwp) begin
      if (int'(bus.cwp_in) < NW) m_cwp = int'(bus.cwp_in);
    end else if (bus.save && !bus.restore) begin
      n = (m_cwp + NW - 1) % NW;
      if (old_wim[n]) e_tov = 1; else m_cwp = n;
    end else if (bus.restore && !bus.save) begin
      n = (m_cwp + 1) % NW;
      if (old_wim[n]) e_tun = 1; else m_cwp = n;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    bus.we,                e_we);
    chk({tag, ".wdata"}, 64'(bus.wdata),        64'(e_wdata));
    chk({tag, ".cwp"},   64'(bus.cwp),          64'(m_cwp));
    chk({tag, ".wim"},   64'(bus.wim),          64'(m_wim));
    chk({tag, ".tov"},   64'(bus.trap_overflow),  64'(e_tov));
    chk({tag, ".tun"},   64'(bus.trap_underflow), 64'(e_tun));
  endtask

  task automatic write(input int r, input logic [DW-1:0] d);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'(r); bus.wr_data = d;
    cyc();
  endtask

  task automatic load_cwp(input int c);
    idle();
    bus.wr_cwp = 1'b1; bus.cwp_in = 5'(c);
    cyc();
  endtask

  initial begin
    logic [63:0] one;
    one = 64'd1;
    idle();
    reset = 1'b1;
    cyc();
    check_all("reset");
    chk("reset.we_zero", bus.we, 64'd0);

    // Basic write and one-cycle latency
    write(5, 32'h0000_1234);
    check_all("w5");
    chk("w5.bit", bus.we, one << 5);
    chk("w5.data", 64'(bus.wdata), 64'h1234);
    idle(); cyc();
    check_all("w5.after");
    chk("w5.after_we", bus.we, 64'd0);

    // Windowed mapping
    write(8, 32'hA);   chk("map.c0r8", bus.we, one << 8);   check_all("map.c0r8");
    write(24, 32'hB);  chk("map.c0r24", bus.we, one << 24); check_all("map.c0r24");
    load_cwp(1);       check_all("ld1");
    write(31, 32'hC);  chk("map.c1r31", bus.we, one << 47); check_all("map.c1r31");
    load_cwp(2);       check_all("ld2");
    write(24, 32'hD);  chk("map.c2r24", bus.we, one << 8);  check_all("map.c2r24");

    // r0 write
    write(0, 32'hFFFF_FFFF);
    chk("r0.we", bus.we, 64'd0);
    chk("r0.data", 64'(bus.wdata), 64'hFFFF_FFFF);
    check_all("r0");

    // SAVE
    load_cwp(0);
    idle(); bus.save = 1'b1; cyc();
    chk("save.cwp", 64'(bus.cwp), 64'd2); check_all("save");
    idle(); bus.wr_wim = 1'b1; bus.wim_in = 3'b010; cyc(); check_all("wim");
    idle(); bus.save = 1'b1; cyc();
    chk("ovf.pulse", 64'(bus.trap_overflow), 64'd1);
    chk("ovf.cwp", 64'(bus.cwp), 64'd2); check_all("ovf");
    idle(); cyc();
    chk("ovf.drop", 64'(bus.trap_overflow), 64'd0); check_all("ovf.after");
    // back-to-back failing SAVEs
    idle(); bus.save = 1'b1; cyc(); check_all("ovf.b2b0");
    idle(); bus.save = 1'b1; cyc(); check_all("ovf.b2b1");
    chk("ovf.b2b_pulse", 64'(bus.trap_overflow), 64'd1);

    // RESTORE / loads
    idle(); bus.restore = 1'b1; cyc();
    chk("rest.cwp", 64'(bus.cwp), 64'd0); check_all("rest");
    idle(); bus.save = 1'b1; bus.restore = 1'b1; cyc();
    chk("both.cwp", 64'(bus.cwp), 64'd0); check_all("both");
    idle(); bus.wr_cwp = 1'b1; bus.cwp_in = 5'd7; bus.save = 1'b1; cyc();
    chk("ld7.cwp", 64'(bus.cwp), 64'd0); check_all("ld7");
    load_cwp(1);
    chk("ld1b.cwp", 64'(bus.cwp), 64'd1); check_all("ld1b");
    // underflow: cwp=0 restore to 1 which is invalid
    load_cwp(0);
    idle(); bus.restore = 1'b1; cyc();
    chk("unf.pulse", 64'(bus.trap_underflow), 64'd1); check_all("unf");

    // Reset dominates
    idle(); reset = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd9;
    bus.wr_data = 32'h5555_AAAA; bus.save = 1'b1; cyc();
    chk("rst.we", bus.we, 64'd0);
    chk("rst.wdata", 64'(bus.wdata), 64'd0);
    check_all("rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      reset       = ($urandom_range(0, 49) == 0);
      bus.wr_en   = $urandom_range(0, 3) != 0;
      bus.wr_addr = 5'($urandom_range(0, 31));
      bus.wr_data = $urandom;
      bus.save    = $urandom_range(0, 3) == 0;
      bus.restore = $urandom_range(0, 3) == 0;
      bus.wr_cwp  = $urandom_range(0, 7) == 0;
      bus.cwp_in  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, NW - 1));
      bus.wr_wim  = $urandom_range(0, 7) == 0;
      bus.wim_in  = NW'($urandom);
      cyc();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
